npxl_empfaenger: RTL

Receiver/decoder for the single-wire NeoPixel (WS2812-style) pulse-width stream produced by the LED driver. Samples the data line at 48 MHz, classifies each high pulse as a 0 or 1, and assembles MSB-first 24-bit colour words. Detects the latch gap that ends a frame. Used for loopback self-test of the driver and as the input stage of a chainable pixel emulator.

---
 rtl/npxl_empfaenger.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/npxl_empfaenger.sv
// NeoPixel (WS2812-style) single-wire receiver: measures high pulse widths on the
// synchronised data line, assembles MSB-first 24-bit words and detects the latch gap.
module npxl_empfaenger #(
  parameter int LEDS          = 20,
  parameter int BIT_THRESHOLD = 30,
  parameter int MIN_HIGH      = 8,
  parameter int MAX_HIGH      = 60,
  parameter int RESET_CYCLES  = 2400
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_npxl_data,
  output logic [23:0]               o_data,
  output logic                      o_valid,
  output logic [$clog2(LEDS)-1:0]   o_led_index,
  output logic                      o_frame_done,
  output logic [$clog2(LEDS):0]     o_word_count,
  output logic                      o_error,
  output logic                      o_overflow
);

  localparam int IDX_W = $clog2(LEDS);
  localparam int WC_W  = IDX_W + 1;

  localparam logic [11:0]     CNT_MAX  = 12'hFFF;
  localparam logic [11:0]     CNT_ONE  = 12'd1;
  localparam logic [11:0]     GAP_LEN  = 12'(RESET_CYCLES);
  localparam logic [11:0]     GAP_LAST = 12'(RESET_CYCLES - 1);
  localparam logic [11:0]     THR      = 12'(BIT_THRESHOLD);
  localparam logic [11:0]     MIN_H    = 12'(MIN_HIGH);
  localparam logic [11:0]     MAX_H    = 12'(MAX_HIGH);
  localparam logic [WC_W-1:0] LEDS_W   = WC_W'(LEDS);
  localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);

  typedef enum logic [1:0] {RESYNC, LOW, HIGH} state_t;

  state_t          state;
  logic            sync_meta;
  logic            s;
  logic            s_prev;
  logic [11:0]     cnt;
  logic [11:0]     cnt_inc;
  logic [4:0]      bit_cnt;
  logic [WC_W-1:0] word_cnt;
  logic [22:0]     shift;
  logic            new_bit;
  logic            rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
      s_prev    <= 1'b0;
    end else begin
      sync_meta <= i_npxl_data;
      s         <= sync_meta;
      s_prev    <= s;
    end
  end

  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    new_bit = (cnt >= THR);
    rise    = s & ~s_prev;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= RESYNC;
      cnt          <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shift        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_led_index  <= '0;
      o_frame_done <= 1'b0;
      o_word_count <= '0;
      o_error      <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_error      <= 1'b0;
      case (state)
        // Only a full latch gap lets decoding start, so we never lock on mid-frame.
        RESYNC: begin
          if (s) begin
            cnt <= '0;
          end else if (cnt == GAP_LAST) begin
            state      <= LOW;
            cnt        <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift      <= '0;
            o_overflow <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= CNT_ONE;
          end else if (cnt < GAP_LEN) begin
            cnt <= cnt_inc;
            if (cnt == GAP_LAST && (word_cnt != '0 || bit_cnt != '0)) begin
              o_frame_done <= 1'b1;
              o_word_count <= word_cnt;
              o_error      <= (bit_cnt != '0);
              word_cnt     <= '0;
              bit_cnt      <= '0;
              shift        <= '0;
              o_overflow   <= 1'b0;
            end
          end
        end
        HIGH: begin
          if (s) begin
            if (cnt >= MAX_H) begin
              o_error <= 1'b1;
              state   <= RESYNC;
              cnt     <= '0;
              bit_cnt <= '0;
              shift   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else if (cnt < MIN_H) begin
            o_error <= 1'b1;
            state   <= RESYNC;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
          end else begin
            shift <= {shift[21:0], new_bit};
            cnt   <= CNT_ONE;
            state <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              // Words beyond LEDS are decoded but suppressed; flag only the first one.
              if (word_cnt < LEDS_W) begin
                o_data      <= {shift, new_bit};
                o_led_index <= word_cnt[IDX_W-1:0];
                o_valid     <= 1'b1;
                word_cnt    <= word_cnt + WC_ONE;
              end else begin
                o_overflow <= 1'b1;
                if (!o_overflow) o_error <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        default: state <= RESYNC;
      endcase
    end
  end

endmodule
